// File: rtl/riscv_rf_mp.sv
// Multi-port integer register file with write-first bypass
// and a per-register busy scoreboard for issue stalls.
module riscv_rf_mp #(
   parameter int              XLEN    = 64,
   parameter int              NREG    = 32,
   parameter int              NRD     = 2,
   parameter int              NWR     = 2,
   parameter int              RST_IDX = 21,
   parameter logic [XLEN-1:0] RST_VAL = 64'h0_800b_6980,
   localparam int             AW      = $clog2(NREG)
) (
   input  logic              i_riscv_rfmp_clk,
   input  logic              i_riscv_rfmp_rst_n,
   input  logic [NRD*AW-1:0] i_riscv_rfmp_rsaddr,
   output logic [NRD*XLEN-1:0] o_riscv_rfmp_rsdata,
   output logic [NRD-1:0]    o_riscv_rfmp_rsbusy,
   input  logic [NWR-1:0]    i_riscv_rfmp_we,
   input  logic [NWR*AW-1:0] i_riscv_rfmp_rdaddr,
   input  logic [NWR*XLEN-1:0] i_riscv_rfmp_rddata,
   input  logic              i_riscv_rfmp_issue,
   input  logic [AW-1:0]     i_riscv_rfmp_issue_rd,
   input  logic              i_riscv_rfmp_flush,
   output logic [AW:0]       o_riscv_rfmp_nbusy
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     cnt_nxt;

   // x0 and out-of-range addresses never touch storage
   function automatic logic in_rng(input logic [AW-1:0] a);
      return (32'(a) < 32'(NREG)) && (a != '0);
   endfunction

   function automatic logic wr_hit(input int w, input logic [AW-1:0] a);
      return i_riscv_rfmp_we[w] && (i_riscv_rfmp_rdaddr[w*AW +: AW] == a);
   endfunction

   always_ff @(posedge i_riscv_rfmp_clk or negedge i_riscv_rfmp_rst_n) begin
      if (!i_riscv_rfmp_rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= (i == RST_IDX) ? RST_VAL : '0;
      end else begin
         for (int w = 0; w < NWR; w++)
            if (i_riscv_rfmp_we[w] && in_rng(i_riscv_rfmp_rdaddr[w*AW +: AW]))
               regs[i_riscv_rfmp_rdaddr[w*AW +: AW]] <= i_riscv_rfmp_rddata[w*XLEN +: XLEN];
      end
   end

   // Bypass is suppressed in reset so reads show the reset contents
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            hit;
      assign a = i_riscv_rfmp_rsaddr[k*AW +: AW];
      always_comb begin
         d   = '0;
         hit = 1'b0;
         if (in_rng(a)) begin
            d = regs[a];
            for (int w = 0; w < NWR; w++)
               if (i_riscv_rfmp_rst_n && wr_hit(w, a)) begin
                  d   = i_riscv_rfmp_rddata[w*XLEN +: XLEN];
                  hit = 1'b1;
               end
         end
      end
      assign o_riscv_rfmp_rsdata[k*XLEN +: XLEN] = d;
      assign o_riscv_rfmp_rsbusy[k] = in_rng(a) && busy[a] && !hit;
   end

   // Issue set is applied after writeback clear so the new producer wins
   always_comb begin
      busy_nxt = busy;
      if (i_riscv_rfmp_flush) begin
         busy_nxt = '0;
      end else begin
         for (int w = 0; w < NWR; w++)
            if (i_riscv_rfmp_we[w] && in_rng(i_riscv_rfmp_rdaddr[w*AW +: AW]))
               busy_nxt[i_riscv_rfmp_rdaddr[w*AW +: AW]] = 1'b0;
         if (i_riscv_rfmp_issue && in_rng(i_riscv_rfmp_issue_rd))
            busy_nxt[i_riscv_rfmp_issue_rd] = 1'b1;
      end
   end

   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NREG; i++)
         cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
   end

   always_ff @(posedge i_riscv_rfmp_clk or negedge i_riscv_rfmp_rst_n) begin
      if (!i_riscv_rfmp_rst_n) begin
         busy               <= '0;
         o_riscv_rfmp_nbusy <= '0;
      end else begin
         busy               <= busy_nxt;
         o_riscv_rfmp_nbusy <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_riscv_rf_mp.sv
// Self-checking bench for riscv_rf_mp: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_riscv_rf_mp;

   localparam logic [63:0] RV = 64'h0_800b_6980;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [9:0]   rsaddr;
   logic [127:0] rsdata;
   logic [1:0]   rsbusy;
   logic [1:0]   we;
   logic [9:0]   rdaddr;
   logic [127:0] rddata;
   logic         issue;
   logic [4:0]   issue_rd;
   logic         flush;
   logic [5:0]   nbusy;

   int checks = 0;
   int errors = 0;

   logic [63:0] m  [32];
   bit          mb [32];

   riscv_rf_mp dut (
      .i_riscv_rfmp_clk      (clk),
      .i_riscv_rfmp_rst_n    (rst_n),
      .i_riscv_rfmp_rsaddr   (rsaddr),
      .o_riscv_rfmp_rsdata   (rsdata),
      .o_riscv_rfmp_rsbusy   (rsbusy),
      .i_riscv_rfmp_we       (we),
      .i_riscv_rfmp_rdaddr   (rdaddr),
      .i_riscv_rfmp_rddata   (rddata),
      .i_riscv_rfmp_issue    (issue),
      .i_riscv_rfmp_issue_rd (issue_rd),
      .i_riscv_rfmp_flush    (flush),
      .o_riscv_rfmp_nbusy    (nbusy)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] exp_data(input int a);
      logic [63:0] d;
      if (a == 0) return 64'h0;
      d = m[a];
      for (int w = 0; w < 2; w++)
         if (rst_n && we[w] && int'(rdaddr[w*5 +: 5]) == a)
            d = rddata[w*64 +: 64];
      return d;
   endfunction

   function automatic bit exp_busy(input int a);
      bit wr = 0;
      for (int w = 0; w < 2; w++)
         if (we[w] && int'(rdaddr[w*5 +: 5]) == a) wr = 1;
      return (a != 0) && mb[a] && !wr;
   endfunction

   function automatic int exp_nbusy();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(mb[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m[i]  = 64'h0;
         mb[i] = 0;
      end
      m[21] = RV;
   endtask

   task automatic model_commit();
      bit nb [32];
      for (int i = 0; i < 32; i++) nb[i] = mb[i];
      for (int w = 0; w < 2; w++)
         if (we[w] && rdaddr[w*5 +: 5] != 0) begin
            m[rdaddr[w*5 +: 5]]  = rddata[w*64 +: 64];
            nb[rdaddr[w*5 +: 5]] = 0;
         end
      if (issue && issue_rd != 0) nb[issue_rd] = 1;
      if (flush)
         for (int i = 0; i < 32; i++) nb[i] = 0;
      for (int i = 0; i < 32; i++) mb[i] = nb[i];
   endtask

   task automatic idle();
      we = 2'b00; rdaddr = '0; rddata = '0;
      issue = 0; issue_rd = '0; flush = 0;
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rsaddr = {5'd5, 5'd21};
      rst_n = 0;
      model_reset();
      #12;
      if (rsdata[63:0] !== RV) begin
         errors++; $display("FAIL reset_x21 got %h want %h", rsdata[63:0], RV);
      end
      checks++;
      if (rsdata[127:64] !== 64'h0) begin
         errors++; $display("FAIL reset_x5 got %h want 0", rsdata[127:64]);
      end
      checks++;
      if (rsbusy !== 2'b00 || nbusy !== 6'd0) begin
         errors++; $display("FAIL reset_busy got %b/%0d want 00/0", rsbusy, nbusy);
      end
      checks++;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_x0();
      idle();
      we = 2'b01; rdaddr = {5'd0, 5'd0}; rddata = {64'h0, 64'hFFFF};
      rsaddr = {5'd0, 5'd0};
      #1;
      if (rsdata[63:0] !== 64'h0) begin
         errors++; $display("FAIL x0_bypass got %h want 0", rsdata[63:0]);
      end
      checks++;
      tick();
      idle();
      #1;
      if (rsdata[63:0] !== 64'h0 || rsbusy[0] !== 1'b0) begin
         errors++; $display("FAIL x0_read got %h/%b want 0/0", rsdata[63:0], rsbusy[0]);
      end
      checks++;
   endtask

   task automatic test_collision();
      idle();
      we = 2'b11; rdaddr = {5'd7, 5'd7};
      rddata = {64'hB, 64'hA};
      rsaddr = {5'd0, 5'd7};
      #1;
      if (rsdata[63:0] !== 64'hB) begin
         errors++; $display("FAIL collide_bypass got %h want b", rsdata[63:0]);
      end
      checks++;
      tick();
      idle();
      #1;
      if (rsdata[63:0] !== 64'hB) begin
         errors++; $display("FAIL collide_store got %h want b", rsdata[63:0]);
      end
      checks++;
   endtask

   task automatic test_bypass();
      idle();
      we = 2'b01; rdaddr = {5'd0, 5'd4}; rddata = {64'h0, 64'h55};
      tick();
      idle();
      we = 2'b10; rdaddr = {5'd3, 5'd0}; rddata = {64'h1234, 64'h0};
      rsaddr = {5'd4, 5'd3};
      #1;
      if (rsdata[63:0] !== 64'h1234) begin
         errors++; $display("FAIL bypass_p0 got %h want 1234", rsdata[63:0]);
      end
      checks++;
      if (rsdata[127:64] !== 64'h55) begin
         errors++; $display("FAIL bypass_p1 got %h want 55", rsdata[127:64]);
      end
      checks++;
      tick();
      idle();
   endtask

   task automatic test_scoreboard();
      idle();
      issue = 1; issue_rd = 5'd9;
      tick();
      idle();
      rsaddr = {5'd0, 5'd9};
      #1;
      if (rsbusy[0] !== 1'b1 || nbusy !== 6'd1) begin
         errors++; $display("FAIL sb_set got %b/%0d want 1/1", rsbusy[0], nbusy);
      end
      checks++;
      we = 2'b01; rdaddr = {5'd0, 5'd9}; rddata = {64'h0, 64'h99};
      #1;
      if (rsbusy[0] !== 1'b0) begin
         errors++; $display("FAIL sb_wb_bypass got %b want 0", rsbusy[0]);
      end
      checks++;
      tick();
      idle();
      #1;
      if (nbusy !== 6'd0 || rsbusy[0] !== 1'b0) begin
         errors++; $display("FAIL sb_clear got %0d/%b want 0/0", nbusy, rsbusy[0]);
      end
      checks++;
      issue = 1; issue_rd = 5'd9;
      tick();
      issue = 1; issue_rd = 5'd9;
      we = 2'b10; rdaddr = {5'd9, 5'd0}; rddata = {64'h77, 64'h0};
      tick();
      idle();
      #1;
      if (rsbusy[0] !== 1'b1 || nbusy !== 6'd1) begin
         errors++; $display("FAIL sb_set_beats_clr got %b/%0d want 1/1", rsbusy[0], nbusy);
      end
      checks++;
   endtask

   task automatic test_flush();
      idle();
      flush = 1;
      tick();
      for (int r = 1; r <= 3; r++) begin
         idle();
         issue = 1; issue_rd = 5'(r);
         tick();
      end
      idle();
      #1;
      if (nbusy !== 6'd3) begin
         errors++; $display("FAIL flush_pre got %0d want 3", nbusy);
      end
      checks++;
      flush = 1; issue = 1; issue_rd = 5'd4;
      tick();
      idle();
      rsaddr = {5'd1, 5'd4};
      #1;
      if (nbusy !== 6'd0 || rsbusy !== 2'b00) begin
         errors++; $display("FAIL flush_post got %0d/%b want 0/00", nbusy, rsbusy);
      end
      checks++;
   endtask

   task automatic test_random();
      idle();
      for (int c = 0; c < 400; c++) begin
         rsaddr   = 10'($urandom);
         we       = 2'($urandom);
         rdaddr   = 10'($urandom);
         rddata   = {$urandom, $urandom, $urandom, $urandom};
         issue    = 1'($urandom);
         issue_rd = 5'($urandom);
         flush    = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) rdaddr[9:5] = rdaddr[4:0];
         if ($urandom_range(0, 3) == 0) rsaddr[4:0] = rdaddr[4:0];
         #1;
         for (int k = 0; k < 2; k++) begin
            if (rsdata[k*64 +: 64] !== exp_data(int'(rsaddr[k*5 +: 5]))) begin
               errors++;
               $display("FAIL rand_data%0d cyc %0d got %h want %h", k, c,
                        rsdata[k*64 +: 64], exp_data(int'(rsaddr[k*5 +: 5])));
            end
            checks++;
            if (rsbusy[k] !== exp_busy(int'(rsaddr[k*5 +: 5]))) begin
               errors++;
               $display("FAIL rand_busy%0d cyc %0d got %b want %b", k, c,
                        rsbusy[k], exp_busy(int'(rsaddr[k*5 +: 5])));
            end
            checks++;
         end
         tick();
         if (int'(nbusy) !== exp_nbusy()) begin
            errors++;
            $display("FAIL rand_nbusy cyc %0d got %0d want %0d", c, nbusy, exp_nbusy());
         end
         checks++;
      end
      idle();
   endtask

   task automatic test_reset_mid();
      idle();
      we = 2'b01; rdaddr = {5'd0, 5'd10}; rddata = {64'h0, 64'hDEAD};
      tick();
      issue = 1; issue_rd = 5'd21;
      tick();
      we = 2'b01; rdaddr = {5'd0, 5'd10}; rddata = {64'h0, 64'hBEEF};
      issue = 1; issue_rd = 5'd10;
      rsaddr = {5'd21, 5'd10};
      #2;
      rst_n = 0;
      model_reset();
      #1;
      if (rsdata[63:0] !== 64'h0 || rsdata[127:64] !== RV) begin
         errors++; $display("FAIL rstmid_in got %h/%h want 0/%h",
                            rsdata[63:0], rsdata[127:64], RV);
      end
      checks++;
      @(posedge clk); #1;
      idle();
      rst_n = 1;
      #1;
      if (rsdata[63:0] !== 64'h0 || rsdata[127:64] !== RV) begin
         errors++; $display("FAIL rstmid_data got %h/%h want 0/%h",
                            rsdata[63:0], rsdata[127:64], RV);
      end
      checks++;
      if (rsbusy !== 2'b00 || nbusy !== 6'd0) begin
         errors++; $display("FAIL rstmid_busy got %b/%0d want 00/0", rsbusy, nbusy);
      end
      checks++;
      tick();
   endtask

   initial begin
      rst_n  = 1;
      rsaddr = '0;
      idle();
      #3;
      test_reset();
      test_x0();
      test_collision();
      test_bypass();
      test_scoreboard();
      test_flush();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
